up_down_counter_param: RTL and testbench

Parametrised synchronous up/down counter with programmable width, terminal value, parallel load, count enable and wrap reporting. It is the general-purpose successor to the team's fixed 3-bit up/down counter, used by datapath controllers as a loop counter and modulo-N sequencer. One clock domain. All state updates on the rising edge of `clk`.

---
 rtl/up_down_counter_param.sv | 97 +++++++++
 tb/tb_up_down_counter_param.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/up_down_counter_param.sv
// up_down_counter_param: parametrised up/down counter, modulo (MAX_VAL+1), with
// parallel load (clamped to MAX_VAL), count enable and a one-cycle wrap pulse.
// Optional feature macro: COUNTER_SAT_EN adds a 'sat' input selecting saturation
// instead of wrap at the ends of the count range.
module up_down_counter_param #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_VAL   = (2 ** WIDTH) - 1,
   parameter int unsigned RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic             up_down,
`ifdef COUNTER_SAT_EN
   input  logic             sat,
`endif
   output logic [WIDTH-1:0] out,
   output logic             wrap,
   output logic             at_max,
   output logic             at_zero
);

   localparam logic [WIDTH-1:0] MaxVal   = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] ResetVal = WIDTH'(RESET_VAL);

   // Reject configurations that cannot hold their own range.
   if (WIDTH < 2) begin : gen_width_chk
      $error("WIDTH must be at least 2");
   end
   if (MAX_VAL < 1 || MAX_VAL > (2 ** WIDTH) - 1) begin : gen_max_chk
      $error("MAX_VAL out of range");
   end
   if (RESET_VAL > MAX_VAL) begin : gen_reset_chk
      $error("RESET_VAL exceeds MAX_VAL");
   end

   logic [WIDTH-1:0] out_q, out_d;
   logic             wrap_q, wrap_d;
   logic             sat_mode;

`ifdef COUNTER_SAT_EN
   assign sat_mode = sat;
`else
   assign sat_mode = 1'b0;
`endif

   // Next-state: load (with clamp) beats count beats hold; wrap only on a wrapping step.
   always_comb begin
      out_d  = out_q;
      wrap_d = 1'b0;
      if (load) begin
         out_d = (data > MaxVal) ? MaxVal : data;
      end else if (en) begin
         if (up_down) begin
            if (out_q >= MaxVal) begin
               if (!sat_mode) begin
                  out_d  = '0;
                  wrap_d = 1'b1;
               end
            end else begin
               out_d = out_q + WIDTH'(1);
            end
         end else begin
            if (out_q == '0) begin
               if (!sat_mode) begin
                  out_d  = MaxVal;
                  wrap_d = 1'b1;
               end
            end else begin
               out_d = out_q - WIDTH'(1);
            end
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         out_q  <= ResetVal;
         wrap_q <= 1'b0;
      end else begin
         out_q  <= out_d;
         wrap_q <= wrap_d;
      end
   end

   // Outputs: registered count and pulse, combinational range flags.
   always_comb begin
      out     = out_q;
      wrap    = wrap_q;
      at_max  = (out_q == MaxVal);
      at_zero = (out_q == '0);
   end

endmodule

// File: tb/tb_up_down_counter_param.sv
// tb_up_down_counter_param: directed self-checking bench, WIDTH=4 MAX_VAL=9 RESET_VAL=0.
// Saturation steps run only when COUNTER_SAT_EN is defined.
module tb_up_down_counter_param;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       load;
   logic [3:0] data;
   logic       up_down;
   logic       sat;
   logic [3:0] out;
   logic       wrap;
   logic       at_max;
   logic       at_zero;

   int checks = 0;
   int errors = 0;

   up_down_counter_param #(
      .WIDTH    (4),
      .MAX_VAL  (9),
      .RESET_VAL(0)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .load   (load),
      .data   (data),
      .up_down(up_down),
`ifdef COUNTER_SAT_EN
      .sat    (sat),
`endif
      .out    (out),
      .wrap   (wrap),
      .at_max (at_max),
      .at_zero(at_zero)
   );

   always #5 clk = ~clk;

   // One rising edge, then settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input int e_out, input int e_wrap);
      chk({tag, ".out"}, int'(out), e_out);
      chk({tag, ".wrap"}, int'(wrap), e_wrap);
      chk({tag, ".at_max"}, int'(at_max), (e_out == 9) ? 1 : 0);
      chk({tag, ".at_zero"}, int'(at_zero), (e_out == 0) ? 1 : 0);
   endtask

   initial begin
      reset = 1'b0; load = 1'b1; data = 4'd5; en = 1'b1; up_down = 1'b1; sat = 1'b0;

      // Reset held for two edges, load pending is ignored
      tick();
      tick();
      chk_state("reset", 0, 0);

      // Up-wrap: ten up steps from 0
      reset = 1'b1; load = 1'b0; en = 1'b1; up_down = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         chk_state($sformatf("up%0d", i), i % 10, (i == 10) ? 1 : 0);
      end

      // Hold clears the wrap pulse
      en = 1'b0;
      tick();
      chk_state("hold0", 0, 0);

      // Down-wrap from 0
      load = 1'b1; data = 4'd0;
      tick();
      chk_state("load0", 0, 0);
      load = 1'b0; en = 1'b1; up_down = 1'b0;
      tick();
      chk_state("down_wrap", 9, 1);
      tick();
      chk_state("down8", 8, 0);

      // Load clamp and priority over en
      load = 1'b1; data = 4'd13; en = 1'b1; up_down = 1'b1;
      tick();
      chk_state("clamp13", 9, 0);
      data = 4'd3;
      tick();
      chk_state("load3", 3, 0);
      load = 1'b0; en = 1'b0;
      tick();
      chk_state("hold3a", 3, 0);
      tick();
      chk_state("hold3b", 3, 0);

      // Direction flips from 7
      load = 1'b1; data = 4'd7;
      tick();
      chk_state("load7", 7, 0);
      load = 1'b0; en = 1'b1; up_down = 1'b1;
      tick();
      chk_state("flip_up", 8, 0);
      up_down = 1'b0;
      tick();
      chk_state("flip_down", 7, 0);
      up_down = 1'b1;
      tick();
      chk_state("flip_up2", 8, 0);
      tick();
      chk_state("to9", 9, 0);

      // Reset at MAX_VAL while counting up (would otherwise wrap)
      reset = 1'b0;
      tick();
      chk_state("mid_reset", 0, 0);
      reset = 1'b1;

`ifdef COUNTER_SAT_EN
      // Saturation at the top, then wrap once sat is released
      load = 1'b1; data = 4'd8;
      tick();
      chk_state("sat_load8", 8, 0);
      load = 1'b0; en = 1'b1; up_down = 1'b1; sat = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_state($sformatf("sat_up%0d", i), 9, 0);
      end
      sat = 1'b0;
      tick();
      chk_state("unsat_wrap", 0, 1);
      // Saturation at the bottom
      sat = 1'b1; up_down = 1'b0;
      tick();
      chk_state("sat_down0", 0, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
